// File: rtl/vga_timing_if.sv
// Raster timing bundle from the timing generator to the first draw stage.
// The generator takes the master side: it receives the advance enable and drives the raster state.
interface vga_timing_if #(
    parameter int CNT_W   = 11,
    parameter int FRAME_W = 8
);
    logic               ce;
    logic [CNT_W-1:0]   hcount;
    logic [CNT_W-1:0]   vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        input  ce,
        output hcount, vcount, hsync, vsync, hblnk, vblnk,
               line_start, frame_start, frame_cnt
    );

    modport slave (
        output ce,
        input  hcount, vcount, hsync, vsync, hblnk, vblnk,
               line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: h/v counters, sync/blank decode, line/frame strobes, frame counter.
// Every decoded output is derived from the next counter value, so it is registered in step with the counters.
module vga_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 144,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 11,
    parameter int FRAME_W  = 8
) (
    input  logic          pclk,
    input  logic          rst,
    vga_timing_if.master  tif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] HS_END_M1  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_END_M1  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_SYNC <= 0 || V_SYNC <= 0) begin : g_bad_sync
        $error("vga_timing_gen: H_SYNC and V_SYNC must be non-zero");
    end
    if ((1 << CNT_W) < H_TOTAL || (1 << CNT_W) < V_TOTAL) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    // Inclusive upper bound keeps the compare inside CNT_W even when the sync ends at TOTAL.
    function automatic logic in_window(input logic [CNT_W-1:0] x,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (x >= lo) && (x <= hi);
    endfunction

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;

    always_comb begin
        h_wrap = (tif.hcount == H_LAST);
        v_wrap = (tif.vcount == V_LAST);
        h_nxt  = h_wrap ? '0 : tif.hcount + CNT_W'(1);
        v_nxt  = tif.vcount;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : tif.vcount + CNT_W'(1);
        end
    end

    // Registered counters and decode, all updated from the same next-state values.
    always_ff @(posedge pclk) begin
        if (rst) begin
            tif.hcount      <= '0;
            tif.vcount      <= '0;
            tif.hblnk       <= 1'b0;
            tif.vblnk       <= 1'b0;
            tif.hsync       <= ~HS_POL;
            tif.vsync       <= ~VS_POL;
            tif.line_start  <= 1'b0;
            tif.frame_start <= 1'b0;
            tif.frame_cnt   <= '0;
        end else if (tif.ce) begin
            tif.hcount      <= h_nxt;
            tif.vcount      <= v_nxt;
            tif.hblnk       <= (h_nxt >= H_ACT_END);
            tif.vblnk       <= (v_nxt >= V_ACT_END);
            tif.hsync       <= sync_level(in_window(h_nxt, HS_START, HS_END_M1), HS_POL);
            tif.vsync       <= sync_level(in_window(v_nxt, VS_START, VS_END_M1), VS_POL);
            tif.line_start  <= h_wrap;
            tif.frame_start <= h_wrap && v_wrap;
            if (h_wrap && v_wrap) begin
                tif.frame_cnt <= tif.frame_cnt + FRAME_W'(1);
            end
        end else begin
            tif.line_start  <= 1'b0;
            tif.frame_start <= 1'b0;
        end
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator for the pixel-clock domain. It generalises the fixed 1024x768 timing block to any resolution, any porch/sync widths and either sync polarity. It adds a clock-enable input, frame/line start strobes and a frame counter. It sits at the head of the draw pipeline and feeds hcount/vcount/sync/blank to the first draw stage.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, horizontal sync width (pixels)
H_BP, 144, horizontal back porch (pixels); H_TOTAL = sum = 1328
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 29, vertical back porch (lines); V_TOTAL = sum = 806
HS_POL, 0, active level of hsync (0 = active-low)
VS_POL, 0, active level of vsync (0 = active-low)
CNT_W, 11, width of hcount/vcount; must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL)
FRAME_W, 8, width of frame counter

Ports:
pclk  in  1  pixel clock
rst  in  1  reset, synchronous, active-high
ce  in  1  advance enable; counters step only when 1
hcount  out  CNT_W  current pixel column, 0..H_TOTAL-1
vcount  out  CNT_W  current line, 0..V_TOTAL-1
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
hblnk  out  1  1 when hcount >= H_ACTIVE
vblnk  out  1  1 when vcount >= V_ACTIVE
line_start  out  1  one-cycle strobe when hcount becomes 0
frame_start  out  1  one-cycle strobe when hcount and vcount both become 0
frame_cnt  out  FRAME_W  completed-frame counter, wraps

Behaviour:
- One clock (pclk). Reset is synchronous, active-high. All outputs are registered.
- Reset values: hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0, frame_cnt=0.
- Counting, on a rising edge with ce=1 and rst=0:
  - hcount increments by 1.
  - At hcount=H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At vcount=V_TOTAL-1 together with hcount=H_TOTAL-1, vcount wraps to 0 and frame_cnt increments, wrapping modulo 2^FRAME_W.
- ce=0: all counters and decoded levels hold their values. Strobes are forced to 0.
- Decode alignment:
  - Every decoded output is computed from the next counter value and registered alongside it.
  - hsync, hblnk and the other decoded outputs therefore always describe the hcount/vcount shown in the same cycle, with zero skew.
- hblnk = (hcount >= H_ACTIVE).
- hsync is active while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC; otherwise inactive.
- vblnk = (vcount >= V_ACTIVE).
- vsync is active while V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC. vsync changes only in the cycle where hcount becomes 0.
- line_start is 1 for exactly one enabled cycle, the one in which hcount becomes 0 from H_TOTAL-1. It is not asserted out of reset.
- frame_start is the line_start that coincides with vcount becoming 0.
- Reset mid-frame returns all counters and outputs to their reset values on the next edge. Counting resumes from (0,0) on the first enabled cycle after rst falls.
- rst has priority over ce.
- Arithmetic:
  - Compare limits are elaboration-time constants of width CNT_W.
  - No counter may exceed its TOTAL-1.
  - Parameter sets with a zero sync width are illegal. They are flagged by an elaboration-time check that prints an error.

Test Plan:
1. Default parameters, ce=1, rst released at cycle 0 -> hcount reaches 1327 then 0; vcount increments at that edge; line period is 1328 cycles; frame period is 1328*806 = 1070368 cycles.
2. Default parameters -> hblnk rises at hcount=1024; hsync goes low at hcount=1048 and returns high at hcount=1184; vsync is low for vcount 771..776 exactly; vblnk is high for vcount 768..805.
3. HS_POL=1, VS_POL=1, small timing (H 8/2/3/2, V 4/1/2/1) -> hsync is high for hcount 10..12 only; vsync is high for vcount 5..6 only; H_TOTAL=15, V_TOTAL=8.
4. ce toggled 1,0,1,0 -> hcount advances only on ce=1 edges; strobes never span a ce=0 cycle; line_start count equals the number of enabled wraps.
5. Assert rst for 1 cycle at hcount=500, vcount=300 -> the next cycle shows hcount=0, vcount=0, hsync=1, blanks=0, frame_cnt=0; no frame_start pulse.
6. Run 257 frames with FRAME_W=8 -> frame_cnt goes 255 -> 0 -> 1; frame_start occurs exactly once per frame, coincident with hcount=0 and vcount=0.
